out_wide_write_packer: RTL and testbench

- Downstream of the sequential bilinear core. Consumes its byte-granular output write stream (address, data, write-enable) and coalesces the bytes into 32-bit words with byte enables for the wide output memory.
- Buffers packed words in a small show-ahead FIFO behind a valid/ready port, so short memory stalls do not lose pixels.
- Provides a flush/drain handshake for end-of-frame, plus byte and word counters that feed the performance counters.

---
 rtl/out_wide_write_packer.sv | 236 +++++++++++++++++++++++
 tb/tb_out_wide_write_packer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/out_wide_write_packer.sv
`default_nettype none
// ============================================================================
// Module      : out_wide_write_packer
// Description : Coalesces a byte write stream into 32-bit words with byte
//               enables and queues them in a show-ahead FIFO for wide memory.
// Revision    : 1.0 - initial release
// ============================================================================
module out_wide_write_packer #(
    parameter int AW    = 10,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clear,
    input  logic          i_flush,
    input  logic          i_we,
    input  logic [AW+1:0] i_baddr,
    input  logic [7:0]    i_wdata,
    output logic [AW-1:0] o_waddr,
    output logic [31:0]   o_wdata,
    output logic [3:0]    o_wbe,
    output logic          o_wvalid,
    input  logic          i_wready,
    output logic          o_busy,
    output logic          o_flush_done,
    output logic          o_overflow,
    output logic [31:0]   o_byte_count,
    output logic [31:0]   o_word_count
);

    localparam int                 c_PTR_W      = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL_COUNT = (c_PTR_W+1)'(DEPTH);
    localparam logic [1:0]         c_S_RUN      = 2'd0;
    localparam logic [1:0]         c_S_FLUSH    = 2'd1;
    localparam logic [1:0]         c_S_DRAIN    = 2'd2;

    logic [1:0]         r_state;
    logic               r_flush_done;
    logic               r_overflow;
    logic [31:0]        r_byte_count;
    logic [31:0]        r_word_count;

    logic               r_acc_valid;
    logic [AW-1:0]      r_acc_addr;
    logic [31:0]        r_acc_data;
    logic [3:0]         r_acc_be;

    logic [AW-1:0]      r_fifo_addr [DEPTH];
    logic [31:0]        r_fifo_data [DEPTH];
    logic [3:0]         r_fifo_be   [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;

    logic [1:0]         w_lane;
    logic [AW-1:0]      w_word;
    logic [3:0]         w_lane_be;
    logic [31:0]        w_lane_mask;
    logic [31:0]        w_lane_data;
    logic [31:0]        w_merge_data;
    logic [3:0]         w_merge_be;

    logic               w_push;
    logic [AW-1:0]      w_push_addr;
    logic [31:0]        w_push_data;
    logic [3:0]         w_push_be;
    logic               w_acc_valid_nxt;
    logic [AW-1:0]      w_acc_addr_nxt;
    logic [31:0]        w_acc_data_nxt;
    logic [3:0]         w_acc_be_nxt;

    logic               w_fifo_empty;
    logic               w_fifo_full;
    logic               w_pop;
    logic               w_push_ok;
    logic               w_drop;

    assign w_lane       = i_baddr[1:0];
    assign w_word       = i_baddr[AW+1:2];
    assign w_lane_be    = 4'b0001 << w_lane;
    assign w_lane_mask  = 32'h0000_00FF << {w_lane, 3'b000};
    assign w_lane_data  = {24'd0, i_wdata} << {w_lane, 3'b000};
    assign w_merge_data = (r_acc_data & ~w_lane_mask) | w_lane_data;
    assign w_merge_be   = r_acc_be | w_lane_be;

    // The flush push owns the single push slot; a byte arriving alongside it
    // always starts a fresh accumulator that belongs to the next frame.
    always_comb begin
        w_push          = 1'b0;
        w_push_addr     = r_acc_addr;
        w_push_data     = r_acc_data;
        w_push_be       = r_acc_be;
        w_acc_valid_nxt = r_acc_valid;
        w_acc_addr_nxt  = r_acc_addr;
        w_acc_data_nxt  = r_acc_data;
        w_acc_be_nxt    = r_acc_be;

        if ((r_state == c_S_FLUSH) && r_acc_valid) begin
            w_push          = 1'b1;
            w_acc_valid_nxt = 1'b0;
            if (i_we) begin
                w_acc_valid_nxt = 1'b1;
                w_acc_addr_nxt  = w_word;
                w_acc_data_nxt  = w_lane_data;
                w_acc_be_nxt    = w_lane_be;
            end
        end else if (i_we) begin
            if (!r_acc_valid) begin
                w_acc_valid_nxt = 1'b1;
                w_acc_addr_nxt  = w_word;
                w_acc_data_nxt  = w_lane_data;
                w_acc_be_nxt    = w_lane_be;
            end else if (r_acc_addr == w_word) begin
                if (w_merge_be == 4'hF) begin
                    w_push          = 1'b1;
                    w_push_data     = w_merge_data;
                    w_push_be       = w_merge_be;
                    w_acc_valid_nxt = 1'b0;
                end else begin
                    w_acc_data_nxt  = w_merge_data;
                    w_acc_be_nxt    = w_merge_be;
                end
            end else begin
                w_push          = 1'b1;
                w_acc_valid_nxt = 1'b1;
                w_acc_addr_nxt  = w_word;
                w_acc_data_nxt  = w_lane_data;
                w_acc_be_nxt    = w_lane_be;
            end
        end
    end

    assign w_fifo_empty = (r_count == '0);
    assign w_fifo_full  = (r_count == c_FULL_COUNT);
    assign w_pop        = !w_fifo_empty && i_wready;
    // A full FIFO still takes a word when its head leaves in the same cycle.
    assign w_push_ok    = w_push && (!w_fifo_full || w_pop);
    assign w_drop       = w_push && w_fifo_full && !w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_S_RUN;
            r_flush_done <= 1'b0;
            r_overflow   <= 1'b0;
            r_byte_count <= '0;
            r_word_count <= '0;
            r_acc_valid  <= 1'b0;
            r_acc_addr   <= '0;
            r_acc_data   <= '0;
            r_acc_be     <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
        end else if (i_clear) begin
            r_state      <= c_S_RUN;
            r_flush_done <= 1'b0;
            r_overflow   <= 1'b0;
            r_byte_count <= '0;
            r_word_count <= '0;
            r_acc_valid  <= 1'b0;
            r_acc_addr   <= '0;
            r_acc_data   <= '0;
            r_acc_be     <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
        end else begin
            r_acc_valid <= w_acc_valid_nxt;
            r_acc_addr  <= w_acc_addr_nxt;
            r_acc_data  <= w_acc_data_nxt;
            r_acc_be    <= w_acc_be_nxt;

            if (i_we) begin
                r_byte_count <= r_byte_count + 32'd1;
            end
            if (w_pop) begin
                r_word_count <= r_word_count + 32'd1;
                r_rd_ptr     <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end

            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase

            r_flush_done <= 1'b0;
            case (r_state)
                c_S_RUN: begin
                    if (i_flush) begin
                        r_state <= c_S_FLUSH;
                    end
                end
                c_S_FLUSH: begin
                    r_state <= c_S_DRAIN;
                end
                c_S_DRAIN: begin
                    if (w_fifo_empty) begin
                        r_state      <= c_S_RUN;
                        r_flush_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_S_RUN;
                end
            endcase
        end
    end

    // Storage needs no reset: the head outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_fifo_addr[r_wr_ptr] <= w_push_addr;
            r_fifo_data[r_wr_ptr] <= w_push_data;
            r_fifo_be[r_wr_ptr]   <= w_push_be;
        end
    end

    assign o_wvalid     = !w_fifo_empty;
    assign o_waddr      = w_fifo_empty ? '0 : r_fifo_addr[r_rd_ptr];
    assign o_wdata      = w_fifo_empty ? '0 : r_fifo_data[r_rd_ptr];
    assign o_wbe        = w_fifo_empty ? '0 : r_fifo_be[r_rd_ptr];
    assign o_busy       = r_acc_valid || !w_fifo_empty || (r_state != c_S_RUN);
    assign o_flush_done = r_flush_done;
    assign o_overflow   = r_overflow;
    assign o_byte_count = r_byte_count;
    assign o_word_count = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_out_wide_write_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_out_wide_write_packer
// Description : Directed, table-driven self-checking bench for the packer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_out_wide_write_packer;

    logic        clk;
    logic        rst_n;
    logic        i_clear;
    logic        i_flush;
    logic        i_we;
    logic [11:0] i_baddr;
    logic [7:0]  i_wdata;
    logic [9:0]  o_waddr;
    logic [31:0] o_wdata;
    logic [3:0]  o_wbe;
    logic        o_wvalid;
    logic        i_wready;
    logic        o_busy;
    logic        o_flush_done;
    logic        o_overflow;
    logic [31:0] o_byte_count;
    logic [31:0] o_word_count;

    int n_checks = 0;
    int n_errors = 0;

    out_wide_write_packer #(.AW(10), .DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (i_clear),
        .i_flush      (i_flush),
        .i_we         (i_we),
        .i_baddr      (i_baddr),
        .i_wdata      (i_wdata),
        .o_waddr      (o_waddr),
        .o_wdata      (o_wdata),
        .o_wbe        (o_wbe),
        .o_wvalid     (o_wvalid),
        .i_wready     (i_wready),
        .o_busy       (o_busy),
        .o_flush_done (o_flush_done),
        .o_overflow   (o_overflow),
        .o_byte_count (o_byte_count),
        .o_word_count (o_word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic        we;
        logic [11:0] baddr;
        logic [7:0]  wdata;
        logic        wready;
        logic        flush;
        logic        exp_wvalid;
        logic [9:0]  exp_waddr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wbe;
        logic [31:0] exp_bytes;
        logic [31:0] exp_words;
        logic        exp_done;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(input logic clr, input logic we, input logic [11:0] ba,
                                input logic [7:0] d, input logic rdy, input logic fl,
                                input logic ev, input logic [9:0] ea, input logic [31:0] ed,
                                input logic [3:0] eb, input logic [31:0] eby,
                                input logic [31:0] ewo, input logic edn);
        vec_t v;
        v.clr = clr; v.we = we; v.baddr = ba; v.wdata = d; v.wready = rdy; v.flush = fl;
        v.exp_wvalid = ev; v.exp_waddr = ea; v.exp_wdata = ed; v.exp_wbe = eb;
        v.exp_bytes = eby; v.exp_words = ewo; v.exp_done = edn;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=0x%h required=0x%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
    endtask

    task automatic wr_byte(input logic [11:0] ba, input logic [7:0] d);
        i_we    = 1'b1;
        i_baddr = ba;
        i_wdata = d;
        tick();
        i_we    = 1'b0;
    endtask

    task automatic check_head(input string name, input logic [9:0] ea, input logic [31:0] ed);
        check({name, " wvalid"}, {31'd0, o_wvalid}, 32'd1);
        check({name, " waddr"}, {22'd0, o_waddr}, {22'd0, ea});
        check({name, " wdata"}, o_wdata, ed);
        check({name, " wbe"}, {28'd0, o_wbe}, 32'hF);
    endtask

    initial begin
        rst_n = 1'b0; i_clear = 1'b0; i_flush = 1'b0; i_we = 1'b0;
        i_baddr = '0; i_wdata = '0; i_wready = 1'b0;

        // clr we baddr data rdy flush | wvalid waddr wdata wbe bytes words done
        vecs[0]  = mk(0,1,12'd0, 8'h11,1,0, 0,10'd0,32'h0,4'h0, 1,0,0);
        vecs[1]  = mk(0,1,12'd1, 8'h22,1,0, 0,10'd0,32'h0,4'h0, 2,0,0);
        vecs[2]  = mk(0,1,12'd2, 8'h33,1,0, 0,10'd0,32'h0,4'h0, 3,0,0);
        vecs[3]  = mk(0,1,12'd3, 8'h44,1,0, 1,10'd0,32'h44332211,4'hF, 4,0,0);
        vecs[4]  = mk(0,0,12'd0, 8'h00,1,0, 0,10'd0,32'h0,4'h0, 4,1,0);
        vecs[5]  = mk(0,1,12'd4, 8'hAA,1,0, 0,10'd0,32'h0,4'h0, 5,1,0);
        vecs[6]  = mk(0,1,12'd5, 8'hBB,1,0, 0,10'd0,32'h0,4'h0, 6,1,0);
        vecs[7]  = mk(0,1,12'd12,8'hCC,1,0, 1,10'd1,32'h0000BBAA,4'h3, 7,1,0);
        vecs[8]  = mk(0,0,12'd0, 8'h00,1,1, 0,10'd0,32'h0,4'h0, 7,2,0);
        vecs[9]  = mk(0,0,12'd0, 8'h00,1,0, 1,10'd3,32'h000000CC,4'h1, 7,2,0);
        vecs[10] = mk(0,0,12'd0, 8'h00,1,0, 0,10'd0,32'h0,4'h0, 7,3,0);
        vecs[11] = mk(0,0,12'd0, 8'h00,1,0, 0,10'd0,32'h0,4'h0, 7,3,1);
        vecs[12] = mk(0,0,12'd0, 8'h00,1,0, 0,10'd0,32'h0,4'h0, 7,3,0);
        vecs[13] = mk(1,0,12'd0, 8'h00,0,0, 0,10'd0,32'h0,4'h0, 0,0,0);
        vecs[14] = mk(0,1,12'd8, 8'h01,0,0, 0,10'd0,32'h0,4'h0, 1,0,0);
        vecs[15] = mk(0,1,12'd8, 8'h02,0,0, 0,10'd0,32'h0,4'h0, 2,0,0);
        vecs[16] = mk(0,0,12'd0, 8'h00,0,1, 0,10'd0,32'h0,4'h0, 2,0,0);
        vecs[17] = mk(0,0,12'd0, 8'h00,0,0, 1,10'd2,32'h00000002,4'h1, 2,0,0);
        vecs[18] = mk(0,0,12'd0, 8'h00,1,0, 0,10'd0,32'h0,4'h0, 2,1,0);
        vecs[19] = mk(0,0,12'd0, 8'h00,1,0, 0,10'd0,32'h0,4'h0, 2,1,1);
        vecs[20] = mk(1,0,12'd0, 8'h00,0,0, 0,10'd0,32'h0,4'h0, 0,0,0);
        vecs[21] = mk(0,0,12'd0, 8'h00,0,1, 0,10'd0,32'h0,4'h0, 0,0,0);
        vecs[22] = mk(0,0,12'd0, 8'h00,0,0, 0,10'd0,32'h0,4'h0, 0,0,0);
        vecs[23] = mk(0,0,12'd0, 8'h00,0,0, 0,10'd0,32'h0,4'h0, 0,0,1);

        #23;
        check("rst wvalid", {31'd0, o_wvalid}, 32'd0);
        check("rst wdata", o_wdata, 32'd0);
        check("rst bytes", o_byte_count, 32'd0);
        check("rst busy", {31'd0, o_busy}, 32'd0);
        check("rst overflow", {31'd0, o_overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 24; i++) begin
            i_clear  = vecs[i].clr;
            i_we     = vecs[i].we;
            i_baddr  = vecs[i].baddr;
            i_wdata  = vecs[i].wdata;
            i_wready = vecs[i].wready;
            i_flush  = vecs[i].flush;
            tick();
            check($sformatf("v%0d wvalid", i), {31'd0, o_wvalid}, {31'd0, vecs[i].exp_wvalid});
            check($sformatf("v%0d waddr", i), {22'd0, o_waddr}, {22'd0, vecs[i].exp_waddr});
            check($sformatf("v%0d wdata", i), o_wdata, vecs[i].exp_wdata);
            check($sformatf("v%0d wbe", i), {28'd0, o_wbe}, {28'd0, vecs[i].exp_wbe});
            check($sformatf("v%0d bytes", i), o_byte_count, vecs[i].exp_bytes);
            check($sformatf("v%0d words", i), o_word_count, vecs[i].exp_words);
            check($sformatf("v%0d flush_done", i), {31'd0, o_flush_done}, {31'd0, vecs[i].exp_done});
        end
        i_clear = 1'b0; i_we = 1'b0; i_flush = 1'b0;

        // Overflow: five words into a four-deep FIFO with the memory stalled.
        do_clear();
        i_wready = 1'b0;
        for (int i = 0; i < 20; i++) wr_byte(12'(i), 8'(i));
        check("ovf overflow", {31'd0, o_overflow}, 32'd1);
        check("ovf bytes", o_byte_count, 32'd20);
        check("ovf words", o_word_count, 32'd0);
        i_wready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check_head($sformatf("ovf beat%0d", k), 10'(k),
                       {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
            tick();
        end
        tick(); tick();
        check("ovf drained", {31'd0, o_wvalid}, 32'd0);
        check("ovf words end", o_word_count, 32'd4);
        check("ovf sticky", {31'd0, o_overflow}, 32'd1);

        // Full FIFO: a completing byte coincides with a pop, so nothing is lost.
        do_clear();
        i_wready = 1'b0;
        for (int i = 0; i < 19; i++) wr_byte(12'(i), 8'(i));
        check("full no ovf yet", {31'd0, o_overflow}, 32'd0);
        i_wready = 1'b1;
        wr_byte(12'd19, 8'd19);
        check("full pushpop ovf", {31'd0, o_overflow}, 32'd0);
        check("full pushpop words", o_word_count, 32'd1);
        for (int k = 1; k < 5; k++) begin
            check_head($sformatf("full beat%0d", k), 10'(k),
                       {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
            tick();
        end
        check("full drained", {31'd0, o_wvalid}, 32'd0);
        check("full words end", o_word_count, 32'd5);

        // Asynchronous reset while draining two queued words.
        do_clear();
        i_wready = 1'b0;
        for (int i = 0; i < 8; i++) wr_byte(12'(i), 8'(i + 8'h40));
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        tick();
        check("drain busy", {31'd0, o_busy}, 32'd1);
        check("drain queued", {31'd0, o_wvalid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst wvalid", {31'd0, o_wvalid}, 32'd0);
        check("arst bytes", o_byte_count, 32'd0);
        check("arst words", o_word_count, 32'd0);
        check("arst busy", {31'd0, o_busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(); tick(); tick();
        check("arst no done", {31'd0, o_flush_done}, 32'd0);
        check("arst idle", {31'd0, o_busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
